// File: rtl/xbar_pkg.sv
// Shared types and widths for the crossbar slave-port arbiter.
package xbar_pkg;

  localparam int XBAR_DATA_W = 32;

  typedef enum logic [2:0] {
    ARB_IDLE = 3'b001,
    ARB_REQ  = 3'b010,
    ARB_RESP = 3'b100
  } arb_state_t;

endpackage

// File: rtl/xbar_rr_picker.sv
// Combinational wrap-around priority search: lowest eligible index at or above i_prio wins.
module xbar_rr_picker #(
  parameter int pMasters = 4,
  parameter int pGrantW  = $clog2(pMasters)
) (
  input  logic [pMasters-1:0] i_eligible,
  input  logic [pGrantW-1:0]  i_prio,
  output logic                o_hit,
  output logic [pGrantW-1:0]  o_index
);

  int w_pos;

  // Scan from the farthest offset down so the nearest eligible master is the last writer.
  always_comb begin
    o_hit   = 1'b0;
    o_index = '0;
    w_pos   = 0;
    for (int k = pMasters - 1; k >= 0; k--) begin
      w_pos = int'(i_prio) + k;
      if (w_pos >= pMasters) w_pos = w_pos - pMasters;
      if (i_eligible[w_pos]) begin
        o_hit   = 1'b1;
        o_index = w_pos[pGrantW-1:0];
      end
    end
  end

endmodule

// File: rtl/xbar_slave_arbiter.sv
// Round-robin arbiter sharing one crossbar slave port between pMasters requesters.
// Optional ARB_REQ abort timer is enabled with `define XBAR_ARB_TIMEOUT_EN.
module xbar_slave_arbiter
  import xbar_pkg::*;
#(
  parameter int pMasters = 4,
  parameter int pGrantW  = $clog2(pMasters),
  parameter int pTimeout = 64
) (
  input  logic                            iClk,
  input  logic                            iRst,
  input  logic [pMasters-1:0]             master_req,
  input  logic [pMasters-1:0]             master_cmd,
  input  logic [pMasters*XBAR_DATA_W-1:0] master_wdata,
  output logic [pMasters-1:0]             master_ack,
  output logic [XBAR_DATA_W-1:0]          master_rdata,
  output logic [pMasters-1:0]             master_err,
  output logic                            slave_req,
  output logic                            slave_cmd,
  output logic [XBAR_DATA_W-1:0]          slave_wdata,
  input  logic                            slave_ack,
  input  logic [XBAR_DATA_W-1:0]          slave_rdata,
  output logic [pGrantW-1:0]              arb_grant,
  output logic                            arb_busy,
  output arb_state_t                      dbg_state
);

  // Handshake: a master holds req with stable cmd/wdata until its one-cycle ack (or err)
  // pulse; toward the slave, req/cmd/wdata are held until slave_ack is seen.
  arb_state_t              r_state;
  logic [pGrantW-1:0]      r_prio;
  logic [pMasters-1:0]     r_mask;
  logic [pGrantW-1:0]      r_grant;
  logic [pMasters-1:0]     r_ack;
  logic [XBAR_DATA_W-1:0]  r_rdata;
  logic                    r_sreq;
  logic                    r_scmd;
  logic [XBAR_DATA_W-1:0]  r_swdata;
  logic                    r_busy;

  logic [pMasters-1:0]     w_eligible;
  logic                    w_hit;
  logic [pGrantW-1:0]      w_index;
  logic [pMasters-1:0]     w_grant_oh;
  logic [pGrantW-1:0]      w_next_prio;

  assign w_eligible  = master_req & ~r_mask;
  assign w_grant_oh  = pMasters'(1) << r_grant;
  assign w_next_prio = (r_grant == pGrantW'(pMasters - 1)) ? '0 : r_grant + 1'b1;

  xbar_rr_picker #(
    .pMasters (pMasters),
    .pGrantW  (pGrantW)
  ) u_picker (
    .i_eligible (w_eligible),
    .i_prio     (r_prio),
    .o_hit      (w_hit),
    .o_index    (w_index)
  );

`ifdef XBAR_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(pTimeout + 1);
  logic [CNT_W-1:0]    r_cnt;
  logic [pMasters-1:0] r_err;
  assign master_err = r_err;
`else
  assign master_err = '0;
`endif

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state  <= ARB_IDLE;
      r_prio   <= '0;
      r_mask   <= '0;
      r_grant  <= '0;
      r_ack    <= '0;
      r_rdata  <= '0;
      r_sreq   <= 1'b0;
      r_scmd   <= 1'b0;
      r_swdata <= '0;
      r_busy   <= 1'b0;
`ifdef XBAR_ARB_TIMEOUT_EN
      r_cnt    <= '0;
      r_err    <= '0;
`endif
    end else begin
      r_ack <= '0;
`ifdef XBAR_ARB_TIMEOUT_EN
      r_err <= '0;
`endif
      case (r_state)
        ARB_IDLE: begin
          // The served master is blocked for exactly this one IDLE cycle.
          r_mask <= '0;
          if (w_hit) begin
            r_grant  <= w_index;
            r_sreq   <= 1'b1;
            r_scmd   <= master_cmd[w_index];
            r_swdata <= master_wdata[w_index*XBAR_DATA_W +: XBAR_DATA_W];
            r_busy   <= 1'b1;
            r_state  <= ARB_REQ;
`ifdef XBAR_ARB_TIMEOUT_EN
            r_cnt    <= '0;
`endif
          end
        end
        ARB_REQ: begin
          if (slave_ack) begin
            r_sreq  <= 1'b0;
            r_state <= ARB_RESP;
          end
`ifdef XBAR_ARB_TIMEOUT_EN
          else if (r_cnt == CNT_W'(pTimeout - 1)) begin
            r_sreq  <= 1'b0;
            r_err   <= w_grant_oh;
            r_prio  <= w_next_prio;
            r_mask  <= w_grant_oh;
            r_busy  <= 1'b0;
            r_state <= ARB_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        ARB_RESP: begin
          r_rdata <= slave_rdata;
          r_ack   <= w_grant_oh;
          r_prio  <= w_next_prio;
          r_mask  <= w_grant_oh;
          r_busy  <= 1'b0;
          r_state <= ARB_IDLE;
        end
        default: begin
          r_sreq  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ARB_IDLE;
        end
      endcase
    end
  end

  assign master_ack   = r_ack;
  assign master_rdata = r_rdata;
  assign slave_req    = r_sreq;
  assign slave_cmd    = r_scmd;
  assign slave_wdata  = r_swdata;
  assign arb_grant    = r_grant;
  assign arb_busy     = r_busy;
  assign dbg_state    = r_state;

endmodule
